tx_frame_scheduler: RTL and testbench

- Shares the single frame transmitter among NUM_REQ payload requesters using round-robin arbitration.
- Latches the winner's 32-bit payload and pulses the transmitter's tx_en for one cycle. It then waits for tx_done and enforces an inter-frame gap before the next grant.
- A watchdog recovers if tx_done never arrives. The block sits between the per-source payload queues and the transmitter.

---
 rtl/eth_mac_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/tx_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_tx_frame_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_pkg.sv
// eth_mac_pkg: state encodings and timing defaults shared across the MAC transmit path
package eth_mac_pkg;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_IFG       = 2'd2;
    localparam int ETH_FRAME_CYCLES   = 32;
    localparam int DEF_IFG_CYCLES     = 12;
    localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner
);
    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;
    // rotate requests so ptr sits at bit 0, find the lowest set bit, then map the offset back
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) off = rot[i] ? PW'(i) : off;
        sum = {1'b0, ptr} + {1'b0, off};
        winner = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
        gnt = '0;
        gnt[winner] = |req;
    end
endmodule

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin sharing of one frame transmitter with inter-frame gap and watchdog
module tx_frame_scheduler
    import eth_mac_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done_ack,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IW = $clog2(IFG_CYCLES + 1) + 1;
    localparam logic [IW-1:0] IFG_LOAD = (IFG_CYCLES > 0) ? IW'(IFG_CYCLES - 1) : '0;

    logic [1:0]         state, state_next;
    logic [PW-1:0]      rr_ptr, rr_ptr_d;
    logic [TW-1:0]      tmo_cnt, tmo_cnt_d;
    logic [IW-1:0]      ifg_cnt, ifg_cnt_d;
    logic [NUM_REQ-1:0] grant_d, done_ack_d, arb_gnt;
    logic [PW-1:0]      arb_winner;
    logic [DATA_W-1:0]  tx_data_d, sel_data;
    logic               tx_en_d, busy_d, timeout_err_d, tmo_hit;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    // payload slice of the arbitration winner
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) sel_data = arb_gnt[i] ? req_data[i*DATA_W +: DATA_W] : sel_data;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // next state: a frame ends on tx_done or watchdog expiry; a zero gap skips IFG entirely
    always_comb begin
        state_next = ST_IDLE;
        if (state == ST_IDLE)
            state_next = (|req) ? ST_WAIT_DONE : ST_IDLE;
        else if (state == ST_WAIT_DONE)
            state_next = (tx_done || tmo_hit) ? ((IFG_CYCLES == 0) ? ST_IDLE : ST_IFG) : ST_WAIT_DONE;
        else if (state == ST_IFG)
            state_next = (ifg_cnt == '0) ? ST_IDLE : ST_IFG;
    end

    // next values of outputs and counters; tx_done beats a simultaneous watchdog expiry
    always_comb begin
        grant_d       = grant;
        tx_data_d     = tx_data;
        rr_ptr_d      = rr_ptr;
        tmo_cnt_d     = tmo_cnt;
        ifg_cnt_d     = ifg_cnt;
        tx_en_d       = 1'b0;
        done_ack_d    = '0;
        timeout_err_d = 1'b0;
        if (state == ST_IDLE && |req) begin
            grant_d   = arb_gnt;
            tx_data_d = sel_data;
            tx_en_d   = 1'b1;
            rr_ptr_d  = (arb_winner == PW'(NUM_REQ - 1)) ? '0 : arb_winner + PW'(1);
            tmo_cnt_d = '0;
        end
        if (state == ST_WAIT_DONE) begin
            tmo_cnt_d = tmo_cnt + TW'(1);
            if (tx_done || tmo_hit) begin
                grant_d       = '0;
                ifg_cnt_d     = IFG_LOAD;
                done_ack_d    = tx_done ? grant : '0;
                timeout_err_d = !tx_done;
            end
        end
        if (state == ST_IFG && ifg_cnt != '0) ifg_cnt_d = ifg_cnt - IW'(1);
        busy_d = (state_next != ST_IDLE);
    end

    // registered outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            done_ack    <= '0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            ifg_cnt     <= '0;
        end else begin
            grant       <= grant_d;
            done_ack    <= done_ack_d;
            tx_en       <= tx_en_d;
            tx_data     <= tx_data_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
            rr_ptr      <= rr_ptr_d;
            tmo_cnt     <= tmo_cnt_d;
            ifg_cnt     <= ifg_cnt_d;
        end
    end
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: random traffic on a 12-cycle-gap and a zero-gap build against a timestamp reference
module tb_tx_frame_scheduler;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   grant [2];
    logic [N-1:0]   done_ack [2];
    logic           tx_en [2];
    logic           busy [2];
    logic           timeout_err [2];
    logic           tx_done [2] = '{1'b0, 1'b0};
    logic [W-1:0]   tx_data [2];
    int n_cmp = 0;
    int n_bad = 0;
    int c = 0;
    int done_at [2] = '{-1, -1};

    typedef struct {
        int owner;
        int ptr;
        int start;
        int free_at;
        logic [N-1:0] grant;
        logic [W-1:0] data;
        logic [N-1:0] ack;
        logic en;
        logic to;
    } mdl_t;
    mdl_t m [2];

    always #5 clk = ~clk;

    tx_frame_scheduler #(.NUM_REQ(N), .DATA_W(W), .IFG_CYCLES(12), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant[0]),
        .done_ack(done_ack[0]), .tx_en(tx_en[0]), .tx_data(tx_data[0]), .tx_done(tx_done[0]),
        .busy(busy[0]), .timeout_err(timeout_err[0])
    );

    tx_frame_scheduler #(.NUM_REQ(N), .DATA_W(W), .IFG_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant[1]),
        .done_ack(done_ack[1]), .tx_en(tx_en[1]), .tx_data(tx_data[1]), .tx_done(tx_done[1]),
        .busy(busy[1]), .timeout_err(timeout_err[1])
    );

    function automatic int ifg_of(int k);
        return (k == 0) ? 12 : 0;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    task automatic model_reset(int k);
        m[k].owner   = -1;
        m[k].ptr     = 0;
        m[k].start   = 0;
        m[k].free_at = 0;
        m[k].grant   = '0;
        m[k].data    = '0;
        m[k].ack     = '0;
        m[k].en      = 1'b0;
        m[k].to      = 1'b0;
    endtask

    // frame owner, start time and earliest next-sample time; outputs follow from those timestamps
    task automatic model_edge(int k);
        logic [N-1:0]   r;
        logic [N*W-1:0] sh;
        int w;
        r = req;
        m[k].en  = 1'b0;
        m[k].ack = '0;
        m[k].to  = 1'b0;
        if (m[k].owner >= 0) begin
            if (tx_done[k] || (c - m[k].start == TMO)) begin
                m[k].ack     = tx_done[k] ? N'(1 << m[k].owner) : '0;
                m[k].to      = !tx_done[k];
                m[k].owner   = -1;
                m[k].grant   = '0;
                m[k].free_at = c + ifg_of(k) + 1;
            end
        end else if (c >= m[k].free_at && r != '0) begin
            w = m[k].ptr;
            while (((r >> w) & N'(1)) == '0) w = (w + 1) % N;
            sh = req_data >> (w * W);
            m[k].owner = w;
            m[k].grant = N'(1 << w);
            m[k].data  = sh[W-1:0];
            m[k].en    = 1'b1;
            m[k].ptr   = (w + 1) % N;
            m[k].start = c;
        end
    endtask

    task automatic compare(int k);
        chk($sformatf("grant%0d", k), 64'(grant[k]), 64'(m[k].grant));
        chk($sformatf("tx_en%0d", k), 64'(tx_en[k]), 64'(m[k].en));
        chk($sformatf("done_ack%0d", k), 64'(done_ack[k]), 64'(m[k].ack));
        chk($sformatf("timeout_err%0d", k), 64'(timeout_err[k]), 64'(m[k].to));
        chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(m[k].owner >= 0 || c + 1 < m[k].free_at));
        if (m[k].owner >= 0) chk($sformatf("tx_data%0d", k), 64'(tx_data[k]), 64'(m[k].data));
    endtask

    // transmitter response: usually a 32-cycle frame, sometimes silent, late, at the watchdog edge, or short
    function automatic int pick_done(int now);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -1;
        if (r == 1) return now + TMO - 1;
        if (r == 2) return now + TMO - 2;
        if (r == 3) return now + $urandom_range(1, 20);
        return now + 32;
    endfunction

    task automatic cycle();
        @(posedge clk);
        c++;
        for (int k = 0; k < 2; k++) if (rst_n) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            compare(k);
            if (rst_n && tx_en[k]) done_at[k] = pick_done(c);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            tx_done[k] = (done_at[k] == c) || (m[k].owner < 0 && $urandom_range(0, 15) == 0);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_grant%0d", k), 64'(grant[k]), 64'(0));
            chk($sformatf("rst_tx_en%0d", k), 64'(tx_en[k]), 64'(0));
            chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'(0));
            chk($sformatf("rst_tx_data%0d", k), 64'(tx_data[k]), 64'(0));
            model_reset(k);
            done_at[k] = -1;
            tx_done[k] = 1'b0;
        end
        repeat (3) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) chk($sformatf("reset_tx_data%0d", k), 64'(tx_data[k]), 64'(0));
        rst_n = 1'b1;
        req = 4'b0010;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        req_data[1*W +: W] = 32'hDEADBEEF;
        cycle();
        chk("single_grant", 64'(grant[0]), 64'(4'b0010));
        chk("single_tx_en", 64'(tx_en[0]), 64'(1));
        chk("single_tx_data", 64'(tx_data[0]), 64'(32'hDEADBEEF));
        repeat (5) cycle();
        req = '0;
        repeat (100) cycle();
        req = 4'b1111;
        for (int i = 0; i < 250; i++) begin
            req_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        for (int i = 0; i < 100 && m[0].owner < 0; i++) cycle();
        chk("mid_frame_owner", 64'(m[0].owner >= 0), 64'(1));
        mid_reset();
        req = 4'b1000;
        cycle();
        chk("post_reset_grant", 64'(grant[0]), 64'(4'b1000));
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            if (m[0].owner >= 0 && $urandom_range(0, 499) == 0) mid_reset();
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
